// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit two's-complement add/subtract that time-shares one 4-bit ripple slice,
// processing one nibble per cycle from the least-significant end, with valid/ready on both sides.
module nibble_serial_addsub #(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NIBBLES-1:0][3:0] a_q, b_q, result_q;
    logic                    sub_q, carry_q, cout_q, ovf_q;
    logic [IDXW-1:0]         idx_q;

    logic [3:0] a_nib, b_nib, sum_nib;
    logic [4:0] c;

    // One 4-bit full-adder ripple; c[3] is the carry into the slice MSB, needed for overflow.
    always_comb begin
        a_nib   = a_q[idx_q];
        b_nib   = b_q[idx_q] ^ {4{sub_q}};
        c       = '0;
        sum_nib = '0;
        c[0]    = carry_q;
        for (int unsigned i = 0; i < 4; i++) begin
            sum_nib[i] = a_nib[i] ^ b_nib[i] ^ c[i];
            c[i+1]     = (a_nib[i] & b_nib[i]) | (c[i] & (a_nib[i] ^ b_nib[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid)     state_d = RUN;
            RUN:     if (idx_q == LAST)   state_d = DONE;
            DONE:    if (res_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        sub_q   <= sub;
                        carry_q <= sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    result_q[idx_q] <= sum_nib;
                    carry_q         <= c[4];
                    if (idx_q == LAST) begin
                        cout_q <= c[4];
                        ovf_q  <= c[4] ^ c[3];
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign result      = result_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboarded bench for nibble_serial_addsub: 16-bit instance plus a single-nibble instance.
module tb_nibble_serial_addsub;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0, start_ready;
    logic [15:0] op_a = '0, op_b = '0;
    logic        sub = 1'b0;
    logic        res_valid, res_ready = 1'b0;
    logic [15:0] result;
    logic        cout, ovf;

    logic        n1_start_valid = 1'b0, n1_start_ready;
    logic [3:0]  n1_op_a = '0, n1_op_b = '0;
    logic        n1_sub = 1'b0;
    logic        n1_res_valid, n1_res_ready = 1'b0;
    logic [3:0]  n1_result;
    logic        n1_cout, n1_ovf;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    nibble_serial_addsub #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .cout(cout), .ovf(ovf)
    );

    nibble_serial_addsub #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start_valid(n1_start_valid), .start_ready(n1_start_ready),
        .op_a(n1_op_a), .op_b(n1_op_b), .sub(n1_sub), .res_valid(n1_res_valid),
        .res_ready(n1_res_ready), .result(n1_result), .cout(n1_cout), .ovf(n1_ovf)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] bb;
        logic [16:0] full;
        exp_t        e;
        bb   = b ^ {16{s}};
        full = {1'b0, a} + {1'b0, bb} + 17'(s);
        e.r  = full[15:0];
        e.c  = full[16];
        e.o  = (a[15] == bb[15]) && (full[15] != a[15]);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        for (int i = 0; i < 50 && !start_ready; i++) @(negedge clk);
        tests++;
        if (start_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_timeout: start_ready=%b required 1", start_ready);
            return;
        end
        op_a = a; op_b = b; sub = s; start_valid = 1'b1;
        sb.push_back(model(a, b, s));
        @(negedge clk);
        start_valid = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom);
    endtask

    task automatic collect(input int stall);
        exp_t e;
        res_ready = 1'b0;
        for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
        tests++;
        if (res_valid !== 1'b1) begin
            fails++;
            $display("FAIL collect_timeout: res_valid=%b required 1", res_valid);
            return;
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: result %h presented with no command pending", result);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i <= stall; i++) begin
            tests++;
            if (res_valid !== 1'b1 || result !== e.r || cout !== e.c || ovf !== e.o) begin
                fails++;
                $display("FAIL result: valid=%b result=%h cout=%b ovf=%b required valid=1 result=%h cout=%b ovf=%b",
                         res_valid, result, cout, ovf, e.r, e.c, e.o);
            end
            if (i < stall) @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            fails++;
            $display("FAIL release: res_valid=%b start_ready=%b required 0/1", res_valid, start_ready);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: start_ready=%b res_valid=%b required 1/0", start_ready, res_valid);
        end
        tests++;
        if (result !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: result=%h cout=%b ovf=%b required 0000/0/0", result, cout, ovf);
        end
        tests++;
        if (n1_start_ready !== 1'b1 || n1_res_valid !== 1'b0 || n1_result !== 4'h0) begin
            fails++;
            $display("FAIL reset_n1: start_ready=%b res_valid=%b result=%h required 1/0/0",
                     n1_start_ready, n1_res_valid, n1_result);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_timing();
        exp_t e;
        op_a = 16'h1234; op_b = 16'h0FFF; sub = 1'b0;
        start_valid = 1'b1; res_ready = 1'b1;
        sb.push_back(model(16'h1234, 16'h0FFF, 1'b0));
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_valid = 1'b0; op_a = 16'hFFFF; op_b = 16'hFFFF; sub = 1'b1;
            end
            tests++;
            if (res_valid !== (c == 5)) begin
                fails++;
                $display("FAIL timing_valid: cycle %0d res_valid=%b required %b", c, res_valid, (c == 5));
            end
            if (c == 5) begin
                e = sb.pop_front();
                tests++;
                if (result !== e.r || cout !== e.c || ovf !== e.o || e.r !== 16'h2233) begin
                    fails++;
                    $display("FAIL add_1234: result=%h cout=%b ovf=%b required %h/%b/%b",
                             result, cout, ovf, e.r, e.c, e.o);
                end
            end
            if (c == 6) begin
                tests++;
                if (start_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL timing_ready: cycle 6 start_ready=%b required 1", start_ready);
                end
            end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_overflow_sub();
        issue(16'h7FFF, 16'h0001, 1'b0); collect(0);
        issue(16'hFFFF, 16'h0001, 1'b0); collect(0);
        issue(16'h0000, 16'h0001, 1'b1); collect(0);
        issue(16'h8000, 16'h0001, 1'b1); collect(0);
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [15:0] snap_r;
        logic        snap_c, snap_o;
        issue(16'hABCD, 16'h1111, 1'b1);
        for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
        snap_r = result; snap_c = cout; snap_o = ovf;
        e = sb.pop_front();
        tests++;
        if (res_valid !== 1'b1 || snap_r !== e.r || snap_c !== e.c || snap_o !== e.o) begin
            fails++;
            $display("FAIL bp_result: valid=%b result=%h cout=%b ovf=%b required 1/%h/%b/%b",
                     res_valid, snap_r, snap_c, snap_o, e.r, e.c, e.o);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                op_a = 16'h5555; op_b = 16'h2222; sub = 1'b0; start_valid = 1'b1;
            end
            if (i == 4) start_valid = 1'b0;
            @(negedge clk);
            tests++;
            if (res_valid !== 1'b1 || result !== snap_r || cout !== snap_c || ovf !== snap_o ||
                start_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold: cycle %0d valid=%b ready=%b result=%h cout=%b ovf=%b required 1/0/%h/%b/%b",
                         i, res_valid, start_ready, result, cout, ovf, snap_r, snap_c, snap_o);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: res_valid=%b start_ready=%b required 0/1", res_valid, start_ready);
        end
        issue(16'h0F0F, 16'h00F1, 1'b0);
        collect(0);
    endtask

    task automatic test_reset_midop();
        op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || result !== 16'h0000 || start_ready !== 1'b1) begin
            fails++;
            $display("FAIL midop_reset: res_valid=%b result=%h start_ready=%b required 0/0000/1",
                     res_valid, result, start_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (res_valid !== 1'b0) begin
                fails++;
                $display("FAIL midop_ghost: cycle %0d res_valid=%b required 0", i, res_valid);
            end
        end
        issue(16'h0005, 16'h0003, 1'b1);
        collect(1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 16; n++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom));
            collect(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_nibbles1();
        n1_op_a = 4'h7; n1_op_b = 4'h1; n1_sub = 1'b0;
        n1_start_valid = 1'b1; n1_res_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n1_start_valid = 1'b0; n1_op_a = 4'hF; n1_op_b = 4'hF;
            end
            tests++;
            if (n1_res_valid !== (c == 2)) begin
                fails++;
                $display("FAIL n1_valid: cycle %0d res_valid=%b required %b", c, n1_res_valid, (c == 2));
            end
            if (c == 2) begin
                tests++;
                if (n1_result !== 4'h8 || n1_cout !== 1'b0 || n1_ovf !== 1'b1) begin
                    fails++;
                    $display("FAIL n1_add: result=%h cout=%b ovf=%b required 8/0/1",
                             n1_result, n1_cout, n1_ovf);
                end
            end
            if (c == 3) begin
                tests++;
                if (n1_start_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL n1_ready: start_ready=%b required 1", n1_start_ready);
                end
            end
        end
        n1_res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_timing();
        test_overflow_sub();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_nibbles1();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d results never produced, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle sequencer that performs WIDTH-bit two's-complement add or subtract by time-sharing one 4-bit add/sub slice (XOR-conditioned B, carry-in = sub, full-adder ripple) over NIBBLES cycles, least-significant nibble first. It owns operand latching, the inter-nibble carry register, nibble indexing and overflow extraction. It presents valid/ready handshakes on both the command and result sides. It sits between a requester issuing wide arithmetic commands and the shared 4-bit adder datapath.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation; WIDTH = 4*NIBBLES; legal range 1..8.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  command present.
- start_ready  out  1  block can accept a command; high only in IDLE.
- op_a  in  WIDTH  operand A, sampled on accept.
- op_b  in  WIDTH  operand B, sampled on accept.
- sub  in  1  0 = A+B, 1 = A-B; sampled on accept.
- res_valid  out  1  result, cout and ovf valid.
- res_ready  in  1  consumer takes result.
- result  out  WIDTH  sum/difference modulo 2^WIDTH.
- cout  out  1  carry out of MSB; for subtract 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: start_ready=1. On start_valid high: latch op_a, op_b, sub; carry_reg <= sub; idx <= 0; -> RUN.
- RUN: each cycle compute slice = A[idx] + (B[idx] XOR {4{sub}}) + carry_reg (5-bit). Write low 4 bits into result[4*idx+3:4*idx]; carry_reg <= bit 4. On idx == NIBBLES-1: cout <= bit 4; ovf <= bit 4 XOR carry into slice bit 3; -> DONE. Otherwise idx <= idx+1.
- DONE: res_valid=1. result/cout/ovf stable until res_ready high; then -> IDLE with res_valid low the next cycle.
- start_valid outside IDLE is ignored (start_ready low); no queueing.
- result bits of nibbles not yet processed hold the previous value during RUN; result is only meaningful when res_valid=1.
- Operands are registered; changes on op_a/op_b/sub after accept have no effect.
- rst in any state: -> IDLE next edge, operation abandoned, no result produced.
- Reset values: start_ready=1 (after reset edge), res_valid=0, result=0, cout=0, ovf=0, idx=0, carry_reg=0.

## Timing
- Command accepted in cycle 0 (start_valid & start_ready at edge 0).
- Nibble k processed in cycle k+1, k = 0..NIBBLES-1.
- res_valid rises in cycle NIBBLES+1 (cycle 5 for default) and stays high until the edge where res_ready=1.
- res_ready high in the first DONE cycle -> IDLE next cycle; next accept earliest cycle NIBBLES+2; minimum initiation interval NIBBLES+2.
- start_ready and res_valid are never high in the same cycle.
- No combinational path from inputs to outputs; all outputs registered or decoded from state.

## Test plan
- Add: A=0x1234, B=0x0FFF, sub=0, res_ready=1 -> result=0x2233, cout=0, ovf=0, res_valid first high exactly in cycle 5, low in cycle 6, start_ready high in cycle 6.
- Signed overflow add: A=0x7FFF, B=0x0001, sub=0 -> result=0x8000, cout=0, ovf=1; A=0xFFFF, B=0x0001 -> result=0x0000, cout=1, ovf=0.
- Subtract: A=0x0000, B=0x0001, sub=1 -> result=0xFFFF, cout=0, ovf=0; A=0x8000, B=0x0001, sub=1 -> result=0x7FFF, cout=1, ovf=1.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid, result, cout, ovf constant; start_valid pulsed meanwhile with other operands is not accepted; res_ready=1 -> returns to IDLE, second command then accepted and completes correctly.
- Reset mid-op: assert rst in cycle 2 of an operation -> next cycle res_valid=0, result=0, start_ready=1; no result ever presented for the abandoned command; following A=0x0005, B=0x0003, sub=1 gives 0x0002, cout=1.
- Back-to-back: 16 random operations with random sub and random res_ready stalls, scoreboarded against (A ± B) mod 2^16 with reference cout/ovf; also run with NIBBLES=1 (A=0x7, B=0x1 add -> 0x8, ovf=1, res_valid in cycle 2).
